// File: rtl/multi_byte_add_sequencer_if.sv
// Request/result handshake bundle for multi_byte_add_sequencer.
// The requester drives the master side; the sequencer uses the slave side.
interface multi_byte_add_sequencer_if #(
  parameter int WORDS = 4
);
  localparam int W = 8 * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;

  modport master (
    output in_valid, op_a, op_b, cin, sub, out_ready,
    input  in_ready, out_valid, result, cout, overflow
  );

  modport slave (
    input  in_valid, op_a, op_b, cin, sub, out_ready,
    output in_ready, out_valid, result, cout, overflow
  );
endinterface

// File: rtl/multi_byte_add_sequencer.sv
// Runs a W-bit add/subtract through one external 8-bit adder, a byte per step,
// LSB first, chaining the carry through a register; holds the result until taken.
module multi_byte_add_sequencer #(
  parameter int WORDS         = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  multi_byte_add_sequencer_if.slave  bus,
  output logic                       busy,
  output logic [7:0]                 add_a,
  output logic [7:0]                 add_b,
  output logic                       add_cin,
  input  logic [7:0]                 add_sum,
  input  logic                       add_cout
);
  localparam int W     = 8 * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       res_q, res_d;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
  // NOTE: the operand/result registers are reset as well, because result,
  // cout and overflow must all read zero straight after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    res_d         = res_q;
    carry_d       = carry_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    add_a         = 8'd0;
    add_b         = 8'd0;
    add_cin       = 1'b0;

    case (state_q)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          // Subtraction is A + ~B + 1: invert B once here, force the first carry.
          a_d     = bus.op_a;
          b_d     = bus.op_b ^ {W{bus.sub}};
          carry_d = bus.sub ? 1'b1 : bus.cin;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        busy    = 1'b1;
        add_a   = a_q[8*idx_q +: 8];
        add_b   = b_q[8*idx_q +: 8];
        add_cin = carry_q;
        if (cnt_q == LAST_CNT) begin
          res_d[8*idx_q +: 8] = add_sum;
          carry_d             = add_cout;
          cnt_d               = '0;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        busy          = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // b_q already holds the inverted operand in subtract mode.
  assign bus.result   = res_q;
  assign bus.cout     = carry_q;
  assign bus.overflow = (a_q[W-1] == b_q[W-1]) && (res_q[W-1] != a_q[W-1]);

endmodule

// File: tb/tb_multi_byte_add_sequencer.sv
// Bench for multi_byte_add_sequencer: one instance with one settle cycle, one with three,
// each driving a behavioural 8-bit adder; results come from plain W-bit arithmetic.
module tb_multi_byte_add_sequencer;
  localparam int WORDS = 4;
  localparam int W     = 32;
  localparam int S0    = 1;
  localparam int S1    = 3;
  localparam longint SMAX = 64'sd2147483647;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic         iv_t   [2];
  logic         cin_t  [2];
  logic         sub_t  [2];
  logic         ordy_t [2];
  logic [W-1:0] op_a_t [2];
  logic [W-1:0] op_b_t [2];
  logic         ir_t   [2];
  logic         ov_t   [2];
  logic         co_t   [2];
  logic         of_t   [2];
  logic         busy_t [2];
  logic [W-1:0] res_t  [2];
  logic [7:0]   aa_t   [2];
  logic [7:0]   ab_t   [2];
  logic         ac_t   [2];
  logic [7:0]   sum_t  [2];
  logic         cout_t [2];

  multi_byte_add_sequencer_if #(.WORDS(WORDS)) bus0 ();
  multi_byte_add_sequencer_if #(.WORDS(WORDS)) bus1 ();

  assign bus0.in_valid  = iv_t[0];
  assign bus0.op_a      = op_a_t[0];
  assign bus0.op_b      = op_b_t[0];
  assign bus0.cin       = cin_t[0];
  assign bus0.sub       = sub_t[0];
  assign bus0.out_ready = ordy_t[0];
  assign ir_t[0]        = bus0.in_ready;
  assign ov_t[0]        = bus0.out_valid;
  assign res_t[0]       = bus0.result;
  assign co_t[0]        = bus0.cout;
  assign of_t[0]        = bus0.overflow;

  assign bus1.in_valid  = iv_t[1];
  assign bus1.op_a      = op_a_t[1];
  assign bus1.op_b      = op_b_t[1];
  assign bus1.cin       = cin_t[1];
  assign bus1.sub       = sub_t[1];
  assign bus1.out_ready = ordy_t[1];
  assign ir_t[1]        = bus1.in_ready;
  assign ov_t[1]        = bus1.out_valid;
  assign res_t[1]       = bus1.result;
  assign co_t[1]        = bus1.cout;
  assign of_t[1]        = bus1.overflow;

  multi_byte_add_sequencer #(.WORDS(WORDS), .SETTLE_CYCLES(S0)) u_dut_s1 (
    .clk(clk), .rst(rst), .bus(bus0), .busy(busy_t[0]),
    .add_a(aa_t[0]), .add_b(ab_t[0]), .add_cin(ac_t[0]),
    .add_sum(sum_t[0]), .add_cout(cout_t[0])
  );

  multi_byte_add_sequencer #(.WORDS(WORDS), .SETTLE_CYCLES(S1)) u_dut_s3 (
    .clk(clk), .rst(rst), .bus(bus1), .busy(busy_t[1]),
    .add_a(aa_t[1]), .add_b(ab_t[1]), .add_cin(ac_t[1]),
    .add_sum(sum_t[1]), .add_cout(cout_t[1])
  );

  // External 8-bit ripple adders.
  for (genvar g = 0; g < 2; g++) begin : g_adder
    assign {cout_t[g], sum_t[g]} = 9'(aa_t[g]) + 9'(ab_t[g]) + 9'(ac_t[g]);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Whole-word reference: unsigned result/carry and true signed range test.
  function automatic void ref_op(input logic [31:0] a, input logic [31:0] b, input logic c,
                                 input logic s, output logic [31:0] r, output logic co,
                                 output logic ov);
    longint      sa, sb, sr;
    logic [32:0] full;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (s) begin
      r  = a - b;
      co = (a >= b);
      sr = sa - sb;
    end else begin
      full = 33'(a) + 33'(b) + 33'(c);
      r    = full[31:0];
      co   = full[32];
      sr   = sa + sb + longint'(c);
    end
    ov = (sr > SMAX) || (sr < -SMAX - 64'sd1);
  endfunction

  // Adder inputs expected while byte k is presented: {a byte, b' byte, carry into byte k}.
  function automatic logic [16:0] ref_step(input logic [31:0] a, input logic [31:0] b,
                                           input logic c, input logic s, input int k);
    logic [31:0] be;
    logic [63:0] mask, low;
    be   = s ? ~b : b;
    mask = (64'd1 << (8 * k)) - 64'd1;
    low  = (64'(a) & mask) + (64'(be) & mask) + 64'(s ? 1'b1 : c);
    return {a[8*k +: 8], be[8*k +: 8], low[8*k]};
  endfunction

  // Full transaction on instance sel; 'stall' cycles of out_ready low with in_valid pushed.
  task automatic run_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                        input logic c, input logic s, input int stall);
    int           settle;
    int           lat;
    logic [31:0]  er;
    logic         eco, eov;
    logic [16:0]  trace[$];
    settle = (sel != 0) ? S1 : S0;
    ref_op(a, b, c, s, er, eco, eov);
    @(negedge clk);
    check("in_ready_idle", 64'(ir_t[sel]), 64'd1);
    op_a_t[sel] = a;
    op_b_t[sel] = b;
    cin_t[sel]  = c;
    sub_t[sel]  = s;
    iv_t[sel]   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv_t[sel]   = 1'b0;
    op_a_t[sel] = $urandom;
    op_b_t[sel] = $urandom;
    sub_t[sel]  = ~s;
    check("in_ready_run", 64'(ir_t[sel]), 64'd0);
    check("busy_run", 64'(busy_t[sel]), 64'd1);
    // out_valid first high in cycle T+1+WORDS*S, i.e. after WORDS*S further edges.
    lat = 0;
    while (!ov_t[sel] && lat < 200) begin
      trace.push_back({aa_t[sel], ab_t[sel], ac_t[sel]});
      @(negedge clk);
      lat++;
    end
    check("latency", 64'(lat), 64'(WORDS * settle));
    check("trace_len", 64'(trace.size()), 64'(WORDS * settle));
    foreach (trace[i]) begin
      if (i < WORDS * settle) check("adder_step", 64'(trace[i]), 64'(ref_step(a, b, c, s, i / settle)));
    end
    check("result", 64'(res_t[sel]), 64'(er));
    check("cout", 64'(co_t[sel]), 64'(eco));
    check("overflow", 64'(of_t[sel]), 64'(eov));
    check("in_ready_done", 64'(ir_t[sel]), 64'd0);
    check("adder_idle_done", 64'({aa_t[sel], ab_t[sel], ac_t[sel]}), 64'd0);
    for (int i = 0; i < stall; i++) begin
      iv_t[sel]   = 1'b1;
      op_a_t[sel] = $urandom;
      @(negedge clk);
      check("stall_out_valid", 64'(ov_t[sel]), 64'd1);
      check("stall_result", 64'({res_t[sel], co_t[sel], of_t[sel]}), 64'({er, eco, eov}));
      check("stall_in_ready", 64'(ir_t[sel]), 64'd0);
    end
    iv_t[sel]   = 1'b0;
    ordy_t[sel] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ordy_t[sel] = 1'b0;
    check("post_out_valid", 64'(ov_t[sel]), 64'd0);
    check("post_in_ready", 64'(ir_t[sel]), 64'd1);
    check("post_busy", 64'(busy_t[sel]), 64'd0);
    check("post_retain", 64'(res_t[sel]), 64'(er));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int           acc[$];
    int           n;
    logic [31:0]  er;
    logic         eco, eov;
    logic [31:0]  ra, rb;

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      iv_t[i] = 1'b0; cin_t[i] = 1'b0; sub_t[i] = 1'b0; ordy_t[i] = 1'b0;
      op_a_t[i] = '0; op_b_t[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_in_ready", 64'(ir_t[i]), 64'd1);
      check("rst_flags", 64'({ov_t[i], busy_t[i], co_t[i], of_t[i]}), 64'd0);
      check("rst_result", 64'(res_t[i]), 64'd0);
    end
    rst = 1'b0;

    // Directed corner operations.
    run_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
    run_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
    run_op(0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 0);
    run_op(0, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 0);
    run_op(0, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 0);
    run_op(0, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b1, 0);
    run_op(0, 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 10);

    // Three settle cycles per byte.
    run_op(1, 32'h80FF_01FF, 32'h7F01_FF01, 1'b1, 1'b0, 0);
    run_op(1, 32'h0000_0100, 32'h0000_0001, 1'b0, 1'b1, 2);

    // Back-to-back throughput with out_ready held high.
    @(negedge clk);
    ordy_t[0] = 1'b1;
    op_a_t[0] = 32'hDEAD_BEEF;
    op_b_t[0] = 32'h1111_2222;
    cin_t[0]  = 1'b0;
    sub_t[0]  = 1'b1;
    iv_t[0]   = 1'b1;
    for (int e = 0; e < 20; e++) begin
      if (ir_t[0]) acc.push_back(e);
      @(negedge clk);
    end
    iv_t[0] = 1'b0;
    check("tput_count", 64'(acc.size() >= 2), 64'd1);
    check("tput_spacing", 64'((acc.size() >= 2) ? acc[1] - acc[0] : -1), 64'(WORDS * S0 + 2));
    n = 0;
    while ((busy_t[0] || !ir_t[0]) && n < 50) begin
      @(negedge clk);
      n++;
    end
    ordy_t[0] = 1'b0;
    ref_op(32'hDEAD_BEEF, 32'h1111_2222, 1'b0, 1'b1, er, eco, eov);
    check("tput_drained", 64'(ir_t[0]), 64'd1);
    check("tput_result", 64'({res_t[0], co_t[0], of_t[0]}), 64'({er, eco, eov}));

    // Reset while byte 2 is on the adder.
    @(negedge clk);
    op_a_t[0] = 32'hA5A5_A5A5;
    op_b_t[0] = 32'h5A5A_5A5A;
    sub_t[0]  = 1'b0;
    cin_t[0]  = 1'b1;
    iv_t[0]   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv_t[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_run_byte2", 64'(aa_t[0]), 64'h A5);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready", 64'(ir_t[0]), 64'd1);
    check("midrst_flags", 64'({ov_t[0], busy_t[0], co_t[0], of_t[0]}), 64'd0);
    check("midrst_result", 64'(res_t[0]), 64'd0);
    check("midrst_adder", 64'({aa_t[0], ab_t[0], ac_t[0]}), 64'd0);
    run_op(0, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1, 1'b0, 0);

    // Random operations on both instances.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 5) == 0) ra = {ra[31], {31{~ra[31]}}};
      if ($urandom_range(0, 5) == 0) rb = ~ra;
      run_op(i % 2, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
